// File: rtl/pc_sequencer.sv
// Multi-cycle PC sequencer: fetches an instruction, decodes control flow,
// resolves branches on the ALU zero flag and pulses the PC write once per instruction.
module pc_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic        zero,
  output logic        instr_req,
  output logic [1:0]  S,
  output logic        pc_we,
  output logic        link_we,
  output logic [31:0] ir,
  output logic [1:0]  state
);

  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] EXEC   = 2'd2;
  localparam logic [1:0] UPDATE = 2'd3;

  localparam logic [1:0] SEL_PC4    = 2'd0;
  localparam logic [1:0] SEL_BRANCH = 2'd1;
  localparam logic [1:0] SEL_JUMP   = 2'd2;
  localparam logic [1:0] SEL_REG    = 2'd3;

  logic [1:0] s_reg;
  logic       link_flag;
  logic       br_pend;
  logic       br_ne;

  logic [1:0] dec_s;
  logic       dec_link;
  logic       dec_br;
  logic       dec_ne;
  logic       br_taken;

  // Handshake: instr_req is the ready side; an instruction transfers on any
  // cycle where instr_req and instr_valid are both high. instr_valid is a
  // don't-care whenever instr_req is low.
  assign instr_req = (state == FETCH) && !reset;
  assign pc_we     = (state == UPDATE);
  assign link_we   = (state == UPDATE) && link_flag;
  assign S         = s_reg;

  always_comb begin
    dec_s    = SEL_PC4;
    dec_link = 1'b0;
    dec_br   = 1'b0;
    dec_ne   = 1'b0;
    case (ir[31:26])
      6'b000010: dec_s = SEL_JUMP;
      6'b000011: begin
        dec_s    = SEL_JUMP;
        dec_link = 1'b1;
      end
      6'b000000: if (ir[5:0] == 6'b001000) dec_s = SEL_REG;
      6'b000100: dec_br = 1'b1;
      6'b000101: begin
        dec_br = 1'b1;
        dec_ne = 1'b1;
      end
      default: dec_s = SEL_PC4;
    endcase
  end

  assign br_taken = br_ne ? !zero : zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      ir        <= 32'd0;
      s_reg     <= SEL_PC4;
      link_flag <= 1'b0;
      br_pend   <= 1'b0;
      br_ne     <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (instr_valid) begin
            ir    <= instr;
            state <= DECODE;
          end
        end
        DECODE: begin
          s_reg     <= dec_s;
          link_flag <= dec_link;
          br_pend   <= dec_br;
          br_ne     <= dec_ne;
          state     <= EXEC;
        end
        EXEC: begin
          // Branch select stays 0 until zero is sampled on this edge.
          if (br_pend) s_reg <= br_taken ? SEL_BRANCH : SEL_PC4;
          state <= UPDATE;
        end
        UPDATE: begin
          s_reg     <= SEL_PC4;
          link_flag <= 1'b0;
          br_pend   <= 1'b0;
          br_ne     <= 1'b0;
          state     <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, reset corner cases and
// randomized instructions against a rule-level select model.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic        zero;
  logic        instr_req;
  logic [1:0]  S;
  logic        pc_we;
  logic        link_we;
  logic [31:0] ir;
  logic [1:0]  state;

  int vectors;
  int miscompares;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .zero(zero), .instr_req(instr_req), .S(S), .pc_we(pc_we),
    .link_we(link_we), .ir(ir), .state(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    int          stall;
    logic        zexec;
    logic [1:0]  exp_s;
    logic        exp_link;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: PC select and link from the instruction's opcode/funct rules.
  function automatic logic [2:0] ref_sel(input logic [31:0] i, input logic z);
    logic [5:0] op;
    op = i[31:26];
    if (op == 6'd2) return {1'b0, 2'd2};
    if (op == 6'd3) return {1'b1, 2'd2};
    if (op == 6'd0 && i[5:0] == 6'd8) return {1'b0, 2'd3};
    if (op == 6'd4) return {1'b0, z ? 2'd1 : 2'd0};
    if (op == 6'd5) return {1'b0, z ? 2'd0 : 2'd1};
    return 3'd0;
  endfunction

  // Runs one instruction from a FETCH-state entry point and checks every cycle.
  task automatic do_instr(input logic [31:0] i, input int stall, input logic zexec,
                          input logic [1:0] exp_s, input logic exp_link);
    logic is_br;
    is_br = (i[31:26] == 6'd4) || (i[31:26] == 6'd5);
    chk("fetch_state", {30'd0, state}, 32'd0);
    chk("fetch_req", {31'd0, instr_req}, 32'd1);
    chk("fetch_pcwe", {31'd0, pc_we}, 32'd0);
    chk("fetch_s", {30'd0, S}, 32'd0);
    for (int k = 0; k < stall; k++) begin
      instr_valid = 1'b0;
      instr = $urandom;
      zero = $urandom_range(0, 1);
      step();
      chk("stall_state", {30'd0, state}, 32'd0);
      chk("stall_pcwe", {31'd0, pc_we}, 32'd0);
      chk("stall_req", {31'd0, instr_req}, 32'd1);
    end
    instr_valid = 1'b1;
    instr = i;
    zero = ~zexec;
    step();
    chk("dec_state", {30'd0, state}, 32'd1);
    chk("dec_ir", ir, i);
    chk("dec_s", {30'd0, S}, 32'd0);
    chk("dec_we", {30'd0, pc_we, link_we}, 32'd0);
    chk("dec_req", {31'd0, instr_req}, 32'd0);
    instr = ~i;
    zero = ~zexec;
    step();
    chk("exec_state", {30'd0, state}, 32'd2);
    chk("exec_ir", ir, i);
    chk("exec_we", {30'd0, pc_we, link_we}, 32'd0);
    if (is_br) chk("exec_br_s", {30'd0, S}, 32'd0);
    zero = zexec;
    step();
    chk("upd_state", {30'd0, state}, 32'd3);
    chk("upd_s", {30'd0, S}, {30'd0, exp_s});
    chk("upd_pcwe", {31'd0, pc_we}, 32'd1);
    chk("upd_link", {31'd0, link_we}, {31'd0, exp_link});
    chk("upd_ir", ir, i);
    zero = ~zexec;
    #4;
    chk("upd_s_stable", {30'd0, S}, {30'd0, exp_s});
    step();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #2;
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_s", {30'd0, S}, 32'd0);
    chk("rst_we", {30'd0, pc_we, link_we}, 32'd0);
    chk("rst_req", {31'd0, instr_req}, 32'd0);
    step();
    chk("rst_hold_we", {30'd0, pc_we, link_we}, 32'd0);
    chk("rst_hold_req", {31'd0, instr_req}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    instr_valid = 1'b0;
    step();
    chk("post_rst_state", {30'd0, state}, 32'd0);
    chk("post_rst_req", {31'd0, instr_req}, 32'd1);
  endtask

  initial begin
    logic [2:0]  m;
    logic [31:0] ri;
    logic        rz;
    int          sel;
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    instr = 32'd0;
    instr_valid = 1'b0;
    zero = 1'b0;

    tbl[0] = '{32'h0000_0020, 0, 1'b0, 2'd0, 1'b0};
    tbl[1] = '{32'h0800_0014, 0, 1'b1, 2'd2, 1'b0};
    tbl[2] = '{32'h0C00_0014, 0, 1'b0, 2'd2, 1'b1};
    tbl[3] = '{32'h03E0_0008, 0, 1'b1, 2'd3, 1'b0};
    tbl[4] = '{32'h1000_000A, 0, 1'b1, 2'd1, 1'b0};
    tbl[5] = '{32'h1000_000A, 1, 1'b0, 2'd0, 1'b0};
    tbl[6] = '{32'h1400_000A, 0, 1'b0, 2'd1, 1'b0};
    tbl[7] = '{32'h1400_000A, 2, 1'b1, 2'd0, 1'b0};
    tbl[8] = '{32'h0000_0020, 5, 1'b1, 2'd0, 1'b0};

    step();
    step();
    apply_reset();

    for (int t = 0; t < 9; t++)
      do_instr(tbl[t].instr, tbl[t].stall, tbl[t].zexec, tbl[t].exp_s, tbl[t].exp_link);

    // Reset during EXEC of a jump: aborted, no PC write.
    instr_valid = 1'b1;
    instr = 32'h0800_0014;
    step();
    instr_valid = 1'b0;
    step();
    chk("abort_exec_state", {30'd0, state}, 32'd2);
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      step();
      chk("abort_no_pcwe", {30'd0, pc_we, link_we}, 32'd0);
      chk("abort_idle_state", {30'd0, state}, 32'd0);
    end

    // Reset during UPDATE of jal: pulses cut off immediately.
    instr_valid = 1'b1;
    instr = 32'h0C00_0014;
    step();
    step();
    step();
    chk("jal_upd_link", {31'd0, link_we}, 32'd1);
    apply_reset();
    step();
    chk("jal_abort_we", {30'd0, pc_we, link_we}, 32'd0);

    // Randomized instruction mix against the rule model.
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 7);
      ri = $urandom;
      case (sel)
        0: ri[31:26] = 6'd2;
        1: ri[31:26] = 6'd3;
        2: begin ri[31:26] = 6'd0; ri[5:0] = 6'd8; end
        3: ri[31:26] = 6'd4;
        4: ri[31:26] = 6'd5;
        5: ri[31:26] = 6'd0;
        6: ri[31:26] = 6'd35;
        default: ;
      endcase
      rz = $urandom_range(0, 1);
      m = ref_sel(ri, rz);
      do_instr(ri, $urandom_range(0, 3), rz, m[1:0], m[2]);
    end
    chk("final_state", {30'd0, state}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
